// File: rtl/wbu_writeback.sv
// wbu_writeback
// Writeback unit owning the single write port of the integer register file.
// Completed results arrive from the LSU path (load data, formatted here by
// funct3/offset) and the ALU path (passed through). One result is accepted per
// cycle, LSU first, and the write port is registered (1-cycle latency).
// A per-register pending-write counter tracks instructions issued but not yet
// written back; decode reads rs1_busy/rs2_busy beside its operand reads.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. ready never depends on the same channel's valid; the producer keeps
// valid and payload stable until that edge.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   issue_valid/issue_ready/issue_rd  dispatch of an instruction writing issue_rd
//   alu_valid/alu_ready/alu_rd/alu_data  ALU result channel
//   lsu_valid/lsu_ready/lsu_rd/lsu_data/lsu_funct3/lsu_offset  load result channel
//   wen/rd_addr/rd_data             registered register-file write port
//   rs1_addr/rs1_busy, rs2_addr/rs2_busy  pending-write lookup for decode
module wbu_writeback #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rd,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [4:0]       alu_rd,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             lsu_valid,
    output logic             lsu_ready,
    input  logic [4:0]       lsu_rd,
    input  logic [WIDTH-1:0] lsu_data,
    input  logic [2:0]       lsu_funct3,
    input  logic [1:0]       lsu_offset,
    output logic             wen,
    output logic [4:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic [4:0]       rs1_addr,
    output logic             rs1_busy,
    input  logic [4:0]       rs2_addr,
    output logic             rs2_busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             wen_q, wen_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];

    logic             lsu_fire;
    logic             alu_fire;
    logic             inc;
    logic             dec;
    logic [WIDTH-1:0] load_b_sh;
    logic [WIDTH-1:0] load_h_sh;
    logic [WIDTH-1:0] load_fmt;

    // Fixed priority: a waiting load always wins the single write slot.
    assign lsu_ready = ~rst;
    assign alu_ready = ~rst & ~lsu_valid;
    assign lsu_fire  = lsu_valid & lsu_ready;
    assign alu_fire  = alu_valid & alu_ready;

    // Writes to x0 never assert wen, so dec needs no x0 test beyond wen.
    assign dec = wen_q & (rd_addr_q != 5'd0);
    assign inc = issue_valid & issue_ready & (issue_rd != 5'd0);

    // A saturated counter can still take a new issue when this cycle's
    // write retires one of its outstanding entries.
    assign issue_ready = ~rst & ((issue_rd == 5'd0)
                                 | (cnt_q[issue_rd] != CNT_MAX)
                                 | (dec & (rd_addr_q == issue_rd)));

    assign rs1_busy = (rs1_addr != 5'd0) & (cnt_q[rs1_addr] != '0);
    assign rs2_busy = (rs2_addr != 5'd0) & (cnt_q[rs2_addr] != '0);

    assign wen     = wen_q;
    assign rd_addr = rd_addr_q;
    assign rd_data = rd_data_q;

    // Load formatting. Halfword loads only honour offset[1].
    always_comb begin
        load_b_sh = lsu_data >> {lsu_offset, 3'b000};
        load_h_sh = lsu_data >> {lsu_offset[1], 4'b0000};
        case (lsu_funct3)
            3'b000:  load_fmt = {{(WIDTH-8){load_b_sh[7]}}, load_b_sh[7:0]};
            3'b100:  load_fmt = {{(WIDTH-8){1'b0}}, load_b_sh[7:0]};
            3'b001:  load_fmt = {{(WIDTH-16){load_h_sh[15]}}, load_h_sh[15:0]};
            3'b101:  load_fmt = {{(WIDTH-16){1'b0}}, load_h_sh[15:0]};
            3'b010:  load_fmt = lsu_data;
            default: load_fmt = lsu_data;
        endcase
    end

    // Write port: address/data only move on a real write, so they hold
    // through idle cycles and accepted x0 results.
    always_comb begin
        wen_d     = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (lsu_fire) begin
            if (lsu_rd != 5'd0) begin
                wen_d     = 1'b1;
                rd_addr_d = lsu_rd;
                rd_data_d = load_fmt;
            end
        end else if (alu_fire) begin
            if (alu_rd != 5'd0) begin
                wen_d     = 1'b1;
                rd_addr_d = alu_rd;
                rd_data_d = alu_data;
            end
        end
    end

    // Pending counters. inc and dec on the same register cancel; dec on an
    // empty counter is a protocol error and leaves it at zero.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (inc && issue_rd == 5'(r) && !(dec && rd_addr_q == 5'(r))) begin
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                end else if (dec && rd_addr_q == 5'(r) && !(inc && issue_rd == 5'(r))
                             && cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
                end
            end else begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q     <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= '0;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            wen_q     <= wen_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Retiring a write nobody issued means the pipeline lost track of a
    // destination.
    always_ff @(posedge clk) begin
        if (!rst && dec) begin
            assert (cnt_q[rd_addr_q] != '0);
        end
    end

endmodule

// File: tb/tb_wbu_writeback.sv
module tb_wbu_writeback;

  localparam int WIDTH = 32;
  localparam int CMAX  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             issue_valid = 0, issue_ready;
  logic [4:0]       issue_rd = 0;
  logic             alu_valid = 0, alu_ready;
  logic [4:0]       alu_rd = 0;
  logic [WIDTH-1:0] alu_data = 0;
  logic             lsu_valid = 0, lsu_ready;
  logic [4:0]       lsu_rd = 0;
  logic [WIDTH-1:0] lsu_data = 0;
  logic [2:0]       lsu_funct3 = 0;
  logic [1:0]       lsu_offset = 0;
  logic             wen;
  logic [4:0]       rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [4:0]       rs1_addr = 0, rs2_addr = 0;
  logic             rs1_busy, rs2_busy;

  wbu_writeback #(.WIDTH(WIDTH), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_offset(lsu_offset),
    .wen(wen), .rd_addr(rd_addr), .rd_data(rd_data),
    .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs2_addr(rs2_addr), .rs2_busy(rs2_busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  logic [36:0] exp_q[$];          // {rd_addr, rd_data} of writes due next cycle
  int          cnt_m[32];         // outstanding writes per register
  logic        exp_now_v = 0;
  logic [4:0]  exp_now_a = 0;
  logic [31:0] exp_now_d = 0;
  logic [4:0]  last_addr = 0;
  logic [31:0] last_data = 0;
  logic        last_known = 0;
  logic        mon_on = 0;
  logic        inc_pend = 0;
  logic [4:0]  inc_rd = 0;
  logic        x0_pend = 0;
  logic        iss_acc, alu_acc, lsu_acc;
  int          owed[32];          // results the bench may still send per register

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] v;
    case (f3)
      3'b000, 3'b100: begin
        v = (d >> (8 * off)) % 256;
        if (f3 == 3'b000 && v >= 128) v = v + 32'hFFFFFF00;
      end
      3'b001, 3'b101: begin
        v = (d >> (16 * off[1])) % 65536;
        if (f3 == 3'b001 && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // Model state advances on each edge: issue/write effects, reset, and the
  // write expected during the coming cycle.
  always @(posedge clk) begin
    logic [36:0] e;
    if (inc_pend) cnt_m[inc_rd]++;
    if (exp_now_v && cnt_m[exp_now_a] > 0) cnt_m[exp_now_a]--;
    inc_pend = 0;
    if (x0_pend) last_known = 0;
    x0_pend = 0;
    exp_now_v = 0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_now_v = 1;
      exp_now_a = e[36:32];
      exp_now_d = e[31:0];
      last_addr = e[36:32];
      last_data = e[31:0];
      last_known = 1;
    end
    if (rst) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
      exp_q.delete();
      exp_now_v = 0;
      last_addr = 0;
      last_data = 0;
      last_known = 1;
      mon_on = 1;
    end
  end

  // Monitor: write port and busy outputs every cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("wen", {31'b0, wen}, {31'b0, exp_now_v});
      if (exp_now_v) begin
        chk("rd_addr", {27'b0, rd_addr}, {27'b0, exp_now_a});
        chk("rd_data", rd_data, exp_now_d);
      end else if (last_known) begin
        chk("rd_addr_hold", {27'b0, rd_addr}, {27'b0, last_addr});
        chk("rd_data_hold", rd_data, last_data);
      end
      chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, (rs1_addr != 0 && cnt_m[rs1_addr] != 0)});
      chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, (rs2_addr != 0 && cnt_m[rs2_addr] != 0)});
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle with the inputs currently applied: check readies,
  // record handshakes and push expected writes.
  task automatic cycle();
    logic exp_ir;
    @(negedge clk);
    exp_ir = !rst && (issue_rd == 0 || cnt_m[issue_rd] != CMAX ||
                      (exp_now_v && exp_now_a == issue_rd));
    chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, !rst});
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, (!rst && !lsu_valid)});
    chk("issue_ready", {31'b0, issue_ready}, {31'b0, exp_ir});
    iss_acc = issue_valid && exp_ir;
    lsu_acc = lsu_valid && !rst;
    alu_acc = alu_valid && !rst && !lsu_valid;
    if (iss_acc && issue_rd != 0) begin
      inc_pend = 1;
      inc_rd = issue_rd;
    end
    if (lsu_acc) begin
      if (lsu_rd != 0) exp_q.push_back({lsu_rd, fmt_load(lsu_data, lsu_funct3, lsu_offset)});
      else x0_pend = 1;
    end else if (alu_acc) begin
      if (alu_rd != 0) exp_q.push_back({alu_rd, alu_data});
      else x0_pend = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0;
    alu_valid = 0;
    lsu_valid = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd);
    issue_valid = 1;
    issue_rd = rd;
    cycle();
    issue_valid = 0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [31:0] d);
    alu_valid = 1;
    alu_rd = rd;
    alu_data = d;
    cycle();
    alu_valid = 0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [31:0] d, input logic [2:0] f3,
                         input logic [1:0] off);
    lsu_valid = 1;
    lsu_rd = rd;
    lsu_data = d;
    lsu_funct3 = f3;
    lsu_offset = off;
    cycle();
    lsu_valid = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic pick_rd(output logic [4:0] rd, output logic ok);
    int s;
    ok = 0;
    rd = 0;
    if ($urandom_range(0, 7) == 0) begin
      ok = 1;
      return;
    end
    s = $urandom_range(0, 31);
    for (int k = 0; k < 32; k++) begin
      if (!ok && ((s + k) % 32) != 0 && owed[(s + k) % 32] > 0) begin
        rd = 5'((s + k) % 32);
        ok = 1;
      end
    end
    if (ok && rd != 0) owed[rd]--;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0] t3_f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
  logic [1:0] t3_off [6] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd1};

  initial begin
    logic [4:0] r;
    logic ok;

    do_reset();

    // Basic ALU writeback with busy tracking on rs1.
    rs1_addr = 5;
    do_issue(5);
    cycle();
    do_alu(5, 32'h0000_1234);
    cycle();
    cycle();

    // Simultaneous LSU and ALU results: LSU first.
    do_issue(3);
    do_issue(4);
    rs1_addr = 3;
    rs2_addr = 4;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'hCAFE_F00D; lsu_funct3 = 3'b010; lsu_offset = 0;
    alu_valid = 1; alu_rd = 4; alu_data = 32'h0BAD_BEEF;
    cycle();
    chk("lsu_first", {31'b0, lsu_acc}, 32'd1);
    lsu_valid = 0;
    cycle();
    chk("alu_second", {31'b0, alu_acc}, 32'd1);
    alu_valid = 0;
    cycle();
    cycle();

    // Load formatting table.
    for (int i = 0; i < 6; i++) do_issue(5'(10 + i));
    for (int i = 0; i < 6; i++) do_load(5'(10 + i), 32'h80FF_7F01, t3_f3[i], t3_off[i]);
    cycle();
    cycle();

    // Counter saturation, then inc and dec on rd 7 in the same cycle.
    rs1_addr = 7;
    do_issue(7);
    do_issue(7);
    do_issue(7);
    issue_valid = 1; issue_rd = 7;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h7777_0001;
    cycle();
    chk("sat_no_issue", {31'b0, iss_acc}, 32'd0);
    alu_valid = 0;
    cycle();
    chk("inc_dec_issue", {31'b0, iss_acc}, 32'd1);
    issue_valid = 0;
    cycle();
    do_alu(7, 32'h7777_0002);
    do_alu(7, 32'h7777_0003);
    do_alu(7, 32'h7777_0004);
    cycle();
    cycle();

    // Writeback to x0.
    rs1_addr = 0;
    do_alu(0, 32'h0000_DEAD);
    chk("x0_accepted", {31'b0, alu_acc}, 32'd1);
    cycle();

    // Reset with outstanding issues and a write in flight.
    rs2_addr = 9;
    do_issue(9);
    do_issue(9);
    do_alu(9, 32'h9999_0001);
    rst = 1;
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h1111_2222; lsu_funct3 = 3'b010;
    cycle();
    rst = 0;
    lsu_valid = 0;
    issue_valid = 1; issue_rd = 9;
    cycle();
    chk("post_rst_issue", {31'b0, iss_acc}, 32'd1);
    issue_valid = 0;

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 32; i++) owed[i] = 0;
    for (int n = 0; n < 800; n++) begin
      if (!alu_valid && $urandom_range(0, 1) == 1) begin
        pick_rd(r, ok);
        if (ok) begin
          alu_valid = 1; alu_rd = r; alu_data = $urandom;
        end
      end
      if (!lsu_valid && $urandom_range(0, 3) == 0) begin
        pick_rd(r, ok);
        if (ok) begin
          lsu_valid = 1; lsu_rd = r; lsu_data = $urandom;
          lsu_funct3 = 3'($urandom_range(0, 7));
          lsu_offset = 2'($urandom_range(0, 3));
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 31));
      cycle();
      if (iss_acc && issue_rd != 0) owed[issue_rd]++;
      if (alu_acc) alu_valid = 0;
      if (lsu_acc) lsu_valid = 0;
    end
    idle();
    cycle();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wbu_writeback.md
Name: wbu_writeback

Overview:
- Writeback unit driving the single write port (wen / rd_addr / rd_data) of the integer register file.
- Accepts completed results from the ALU path and the LSU path via valid/ready and formats load data by funct3. Arbitrates one write per cycle and registers the write port.
- Keeps a per-register pending-write scoreboard. Decode reads it next to its rs1/rs2 reads, so it does not consume stale operands.

Parameters:
- WIDTH, 32, data width of results and register-file write data.
- CNT_W, 2, width of each per-register pending counter; maximum outstanding writes per register is 2^CNT_W - 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- issue_valid  in  1  decode dispatches an instruction writing issue_rd
- issue_ready  out  1  dispatch may proceed (issue_rd counter not saturated)
- issue_rd  in  5  destination of the dispatched instruction
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination
- alu_data  in  WIDTH  ALU result
- lsu_valid  in  1  load data available
- lsu_ready  out  1  load result accepted this cycle
- lsu_rd  in  5  load destination
- lsu_data  in  WIDTH  raw aligned memory word
- lsu_funct3  in  3  load type
- lsu_offset  in  2  address bits [1:0]
- wen  out  1  register-file write enable
- rd_addr  out  5  register-file write address
- rd_data  out  WIDTH  register-file write data
- rs1_addr  in  5  decode source 1
- rs1_busy  out  1  rs1 has a pending write
- rs2_addr  in  5  decode source 2
- rs2_busy  out  1  rs2 has a pending write

Behaviour:
- Reset (clk edge with rst=1): wen=0, rd_addr=0, rd_data=0, all counters=0.
  - In-flight results and pending issues are discarded.
  - rst overrides every simultaneous handshake.
- Arbitration, fixed priority LSU over ALU:
  - lsu_ready = ~rst.
  - alu_ready = ~rst & ~lsu_valid.
  - At most one handshake per cycle.
- Write port is registered; latency is 1 cycle.
  - Handshake at edge N: wen=1 during cycle N+1 with the captured rd_addr/rd_data, so the register file writes at edge N+1.
  - No handshake at edge N: wen=0 in cycle N+1, and rd_addr/rd_data hold their previous values.
- Destination x0: the request is accepted normally but wen stays 0, and no counter changes.
- Load formatting, with sh = lsu_offset*8 and the value shifted right by sh:
  - funct3 000 LB: sign-extend bits [7:0].
  - funct3 100 LBU: zero-extend bits [7:0].
  - funct3 001 LH: sign-extend bits [15:0], using offset[1] only.
  - funct3 101 LHU: zero-extend bits [15:0], using offset[1] only.
  - funct3 010 LW: whole word, offset ignored.
  - Any other funct3: lsu_data passed unshifted.
- ALU data passes unmodified.
- Scoreboard: counter cnt[r] for r = 1..31; cnt[0] is constant 0.
  - inc = issue_valid & issue_ready & issue_rd != 0, applied to issue_rd.
  - dec = wen & rd_addr != 0, applied to rd_addr, at the same edge as the register-file write.
  - inc and dec on the same register in the same cycle: net unchanged. On different registers: both applied.
- issue_ready = ~rst & (issue_rd == 0 | cnt[issue_rd] != max | dec hits issue_rd this cycle).
- dec on a counter already at 0 is a protocol error: the counter stays at 0 and a simulation assertion fires.
- Busy outputs are combinational from registered counters: rs*_busy = (rs*_addr != 0) & (cnt[rs*_addr] != 0).
  - Busy clears in the cycle after the register-file update, so a read that sees busy=0 always sees the new data.

Test Plan:
- Reset, then issue rd=5 and ALU rd=5 data=0x1234 → rs1_busy(5)=1 until wen=1, rd_addr=5, rd_data=0x1234 one cycle after the handshake; busy=0 the following cycle.
- lsu_valid and alu_valid together (rd 3 / rd 4) → LSU accepted first, alu_ready=0; ALU accepted next cycle; wen pulses for rd 3 then rd 4 on consecutive cycles.
- lsu_data=0x80FF7F01 → results:
  - LB offset 3: 0xFFFFFF80
  - LBU offset 3: 0x00000080
  - LH offset 2: 0xFFFF80FF
  - LHU offset 0: 0x00007F01
  - LW: 0x80FF7F01
- Issue rd=7 three times → issue_ready=0 on the fourth; an inc and dec on rd 7 in the same cycle → counter stays at 3 and issue_ready=1.
- ALU writeback to rd=0 with data 0xDEAD → alu_ready=1, wen stays 0, rs1_busy(0)=0.
- rst asserted with cnt[9]=2 and a pending write → next cycle wen=0, rs2_busy(9)=0, issue_ready=1.
